// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment driver: one digit per scan_clk period, inputs latched once per frame.
// Optional anode dead-time between digits when SEG7_BLANKING_EN is defined.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 100
) (
    input  logic                    clk_100M,
    input  logic                    rst,
    input  logic                    scan_clk,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || BLANK_CYCLES < 1 || BLANK_CYCLES > 1999) begin : g_param_err
        $error("seg7_scan_driver: parameter out of range");
    end

    logic                    sync1, sync2, sync3;
    logic                    scan_tick;
    logic [IDX_W-1:0]        idx, idx_nxt, drv_idx;
    logic                    frame_nxt;
    logic [4*NUM_DIGITS-1:0] val_l, val_use;
    logic [NUM_DIGITS-1:0]   dp_l, dp_use, mask_l, mask_use;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   drv_an;
    logic [6:0]              drv_seg;
    logic                    drv_dp;

    assign scan_tick = sync2 & ~sync3;

    // The digit about to be shown: on a tick it is the new index with (possibly) freshly latched inputs.
    always_comb begin
        idx_nxt   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        frame_nxt = scan_tick && (idx_nxt == '0);
        drv_idx   = scan_tick ? idx_nxt : idx;
        val_use   = frame_nxt ? value      : val_l;
        dp_use    = frame_nxt ? dp_in      : dp_l;
        mask_use  = frame_nxt ? blank_mask : mask_l;
        nib       = val_use[{drv_idx, 2'b00} +: 4];
        case (nib)
            4'h0: drv_seg = 7'h40;
            4'h1: drv_seg = 7'h79;
            4'h2: drv_seg = 7'h24;
            4'h3: drv_seg = 7'h30;
            4'h4: drv_seg = 7'h19;
            4'h5: drv_seg = 7'h12;
            4'h6: drv_seg = 7'h02;
            4'h7: drv_seg = 7'h78;
            4'h8: drv_seg = 7'h00;
            4'h9: drv_seg = 7'h10;
            4'hA: drv_seg = 7'h08;
            4'hB: drv_seg = 7'h03;
            4'hC: drv_seg = 7'h46;
            4'hD: drv_seg = 7'h21;
            4'hE: drv_seg = 7'h06;
            default: drv_seg = 7'h0E;
        endcase
        drv_dp          = ~dp_use[drv_idx];
        drv_an          = '1;
        drv_an[drv_idx] = 1'b0;
        if (mask_use[drv_idx]) begin
            drv_an  = '1;
            drv_seg = 7'h7F;
            drv_dp  = 1'b1;
        end
    end

`ifdef SEG7_BLANKING_EN
    localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
    logic [CNT_W-1:0] blank_cnt;
`endif

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            idx         <= LAST_IDX;
            val_l       <= '0;
            dp_l        <= '0;
            mask_l      <= '0;
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
`ifdef SEG7_BLANKING_EN
            blank_cnt   <= '0;
`endif
        end else begin
            sync1       <= scan_clk;
            sync2       <= sync1;
            sync3       <= sync2;
            frame_start <= frame_nxt;
            if (scan_tick) begin
                idx <= idx_nxt;
            end
            if (frame_nxt) begin
                val_l  <= value;
                dp_l   <= dp_in;
                mask_l <= blank_mask;
            end
`ifdef SEG7_BLANKING_EN
            // Dark window starts right after the tick; a new tick restarts it.
            if (scan_tick) begin
                an        <= '1;
                seg       <= 7'h7F;
                dp        <= 1'b1;
                blank_cnt <= CNT_W'(BLANK_CYCLES);
            end else if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - 1'b1;
                if (blank_cnt == CNT_W'(1)) begin
                    an  <= drv_an;
                    seg <= drv_seg;
                    dp  <= drv_dp;
                end
            end
`else
            if (scan_tick) begin
                an  <= drv_an;
                seg <= drv_seg;
                dp  <= drv_dp;
            end
`endif
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4); define SEG7_BLANKING_EN to check the dead-time build.
module tb_seg7_scan_driver;
    localparam int BLANK = 100;
`ifdef SEG7_BLANKING_EN
    localparam int HALF = 150;
`else
    localparam int HALF = 20;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_clk = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    seg7_scan_driver #(.NUM_DIGITS(4), .BLANK_CYCLES(BLANK)) dut (
        .clk_100M(clk), .rst(rst), .scan_clk(scan_clk), .value(value), .dp_in(dp_in),
        .blank_mask(blank_mask), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dpi;
        logic [3:0]  mask;
        exp_t        e;
    } vec_t;

    exp_t       sbq[$];
    vec_t       vecs[28];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         fs_count = 0;
    logic [3:0] prev_an = 4'hF;

    always @(negedge clk) if (frame_start === 1'b1) fs_count++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One scan_clk period: high for 'half' cycles, then low for 'half' cycles.
    task automatic pulse(input int half, input exp_t e);
        exp_t got;
        int   used;
        got = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
        sbq.push_back(e);
        scan_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("latency_hold_an", an, prev_an);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            got = sbq.pop_front();
        end
        check("frame_start", frame_start, got.fs);
        used = 3;
`ifdef SEG7_BLANKING_EN
        check("dark_an", an, 4'hF);
        check("dark_seg", seg, 7'h7F);
        check("dark_dp", dp, 1'b1);
        repeat (BLANK - 1) @(posedge clk);
        #1 check("dark_last_an", an, 4'hF);
        @(posedge clk);
        #1;
        used += BLANK;
`endif
        check("digit_an", an, got.an);
        check("digit_seg", seg, got.seg);
        check("digit_dp", dp, got.dp);
        @(posedge clk);
        #1 check("frame_start_end", frame_start, 1'b0);
        used++;
        repeat (half - used) @(posedge clk);
        #1 scan_clk = 1'b0;
        repeat (half) @(posedge clk);
        #1;
        check("hold_an", an, got.an);
        check("hold_seg", seg, got.seg);
        prev_an = got.an;
    endtask

    function automatic vec_t mk(input logic [15:0] v, input logic [3:0] d, input logic [3:0] m,
                                input logic [3:0] a, input logic [6:0] s, input logic p, input logic f);
        vec_t r;
        r.value = v; r.dpi = d; r.mask = m;
        r.e = '{an: a, seg: s, dp: p, fs: f};
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(16'h12AF, 4'h0, 4'h0, 4'hE, 7'h0E, 1'b1, 1'b1);
        vecs[1]  = mk(16'h12AF, 4'h0, 4'h0, 4'hD, 7'h08, 1'b1, 1'b0);
        vecs[2]  = mk(16'h12AF, 4'h0, 4'h0, 4'hB, 7'h24, 1'b1, 1'b0);
        vecs[3]  = mk(16'h12AF, 4'h0, 4'h0, 4'h7, 7'h79, 1'b1, 1'b0);
        vecs[4]  = mk(16'h0000, 4'h0, 4'h0, 4'hE, 7'h40, 1'b1, 1'b1);
        vecs[5]  = mk(16'hFFFF, 4'h0, 4'h0, 4'hD, 7'h40, 1'b1, 1'b0);
        vecs[6]  = mk(16'hFFFF, 4'h0, 4'h0, 4'hB, 7'h40, 1'b1, 1'b0);
        vecs[7]  = mk(16'hFFFF, 4'hF, 4'hF, 4'h7, 7'h40, 1'b1, 1'b0);
        vecs[8]  = mk(16'hFFFF, 4'h0, 4'h0, 4'hE, 7'h0E, 1'b1, 1'b1);
        vecs[9]  = mk(16'hFFFF, 4'h0, 4'h0, 4'hD, 7'h0E, 1'b1, 1'b0);
        vecs[10] = mk(16'hFFFF, 4'h0, 4'h0, 4'hB, 7'h0E, 1'b1, 1'b0);
        vecs[11] = mk(16'hFFFF, 4'h0, 4'h0, 4'h7, 7'h0E, 1'b1, 1'b0);
        vecs[12] = mk(16'h1234, 4'h2, 4'h5, 4'hF, 7'h7F, 1'b1, 1'b1);
        vecs[13] = mk(16'h1234, 4'h2, 4'h5, 4'hD, 7'h30, 1'b0, 1'b0);
        vecs[14] = mk(16'h1234, 4'h2, 4'h5, 4'hF, 7'h7F, 1'b1, 1'b0);
        vecs[15] = mk(16'h1234, 4'h2, 4'h5, 4'h7, 7'h79, 1'b1, 1'b0);
        vecs[16] = mk(16'h8C5E, 4'hF, 4'h0, 4'hE, 7'h06, 1'b0, 1'b1);
        vecs[17] = mk(16'h8C5E, 4'hF, 4'h0, 4'hD, 7'h12, 1'b0, 1'b0);
        vecs[18] = mk(16'h8C5E, 4'hF, 4'h0, 4'hB, 7'h46, 1'b0, 1'b0);
        vecs[19] = mk(16'h8C5E, 4'hF, 4'h0, 4'h7, 7'h00, 1'b0, 1'b0);
        vecs[20] = mk(16'h4DB7, 4'h4, 4'h0, 4'hE, 7'h78, 1'b1, 1'b1);
        vecs[21] = mk(16'h4DB7, 4'h4, 4'h0, 4'hD, 7'h03, 1'b1, 1'b0);
        vecs[22] = mk(16'h4DB7, 4'h4, 4'h0, 4'hB, 7'h21, 1'b0, 1'b0);
        vecs[23] = mk(16'h4DB7, 4'h4, 4'h0, 4'h7, 7'h19, 1'b1, 1'b0);
        vecs[24] = mk(16'h6930, 4'h0, 4'h0, 4'hE, 7'h40, 1'b1, 1'b1);
        vecs[25] = mk(16'h6930, 4'h0, 4'h0, 4'hD, 7'h30, 1'b1, 1'b0);
        vecs[26] = mk(16'h6930, 4'h0, 4'h0, 4'hB, 7'h10, 1'b1, 1'b0);
        vecs[27] = mk(16'h6930, 4'h0, 4'h0, 4'h7, 7'h02, 1'b1, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_frame_start", frame_start, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Table: first frame at the real 2000-cycle slot rate, the rest faster.
        for (int i = 0; i < 28; i++) begin
            value      = vecs[i].value;
            dp_in      = vecs[i].dpi;
            blank_mask = vecs[i].mask;
            pulse((i < 4) ? 1000 : HALF, vecs[i].e);
        end

        // scan_clk stuck low: digit 3 of 16'h6930 stays lit, no frame_start.
        begin
            int fs_before;
            fs_before = fs_count;
            repeat (10000) @(posedge clk);
            #1;
            check("stuck_an", an, 4'h7);
            check("stuck_seg", seg, 7'h02);
            check("stuck_frame_starts", fs_count, fs_before);
        end
        pulse(HALF, '{an: 4'hE, seg: 7'h40, dp: 1'b1, fs: 1'b1});
        pulse(HALF, '{an: 4'hD, seg: 7'h30, dp: 1'b1, fs: 1'b0});
        pulse(HALF, '{an: 4'hB, seg: 7'h10, dp: 1'b1, fs: 1'b0});

        // Asynchronous reset mid-cycle with digit 2 lit.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_dp", dp, 1'b1);
        check("midrst_frame_start", frame_start, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        prev_an = 4'hF;
        value = 16'hA5C3;
        dp_in = 4'h0;
        blank_mask = 4'h0;
        pulse(HALF, '{an: 4'hE, seg: 7'h30, dp: 1'b1, fs: 1'b1});
        pulse(HALF, '{an: 4'hD, seg: 7'h46, dp: 1'b1, fs: 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
